// File: rtl/fifo_modport.sv
// Single-clock synchronous FIFO with a registered read port.
// Occupancy is tracked by an explicit counter. All four status flags are
// decoded from that registered counter, so each flag changes in the cycle
// after the edge that accepts the write or read.
module fifo_modport #(
  parameter int DATA_W       = 128,
  parameter int DEPTH        = 1024,
  parameter int ALM_FULL_TH  = 1020,
  parameter int ALM_EMPTY_TH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_wren,
  input  logic              i_rden,
  input  logic [DATA_W-1:0] i_wrdata,
  output logic              o_full,
  output logic              o_empty,
  output logic              o_alm_full,
  output logic              o_alm_empty,
  output logic [DATA_W-1:0] o_rddata
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // Thresholds resized to the counter width so the flag compares stay
  // width-matched.
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_CNT = CW'(ALM_FULL_TH);
  localparam logic [CW-1:0] AEMPT_CNT = CW'(ALM_EMPTY_TH);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  // Storage array. It has no reset, so it can map onto block RAM.
  logic [DATA_W-1:0] mem [DEPTH];

  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [DATA_W-1:0] rddata_q;

  logic wr_acc;
  logic rd_acc;
  logic full_w;
  logic empty_w;

  // Status decode from the registered occupancy.
  assign full_w      = (count_q == FULL_CNT);
  assign empty_w     = (count_q == '0);
  assign o_full      = full_w;
  assign o_empty     = empty_w;
  assign o_alm_full  = (count_q >= AFULL_CNT);
  assign o_alm_empty = (count_q <= AEMPT_CNT);
  assign o_rddata    = rddata_q;

  // Requests against a full or empty FIFO are dropped here. When the FIFO is
  // full, a simultaneous read still goes through. When it is empty, a
  // simultaneous write still goes through.
  assign wr_acc = i_wren & ~full_w;
  assign rd_acc = i_rden & ~empty_w;

  // Next-state pointers and occupancy. Pointers wrap naturally at DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (rd_acc) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    unique case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Memory write port.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr_q] <= i_wrdata;
    end
  end

  // Control state and registered read data. Reset empties the FIFO at once,
  // without waiting for a clock edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rddata_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (rd_acc) begin
        rddata_q <= mem[rd_ptr_q];
      end
    end
  end

endmodule

// File: tb/tb_fifo_modport.sv
// Directed bench for fifo_modport.
// A table of vectors covers the ordered-data and underflow cases, and the
// almost-empty boundary. Hand sequences cover fill and overflow, drain,
// simultaneous access, wrap-around streaming and asynchronous reset. A queue
// scoreboard supplies the expected values for the hand sequences.
module tb_fifo_modport;

  localparam int DW    = 128;
  localparam int DEPTH = 1024;
  localparam int AFTH  = 1020;
  localparam int AETH  = 4;

  logic          clk;
  logic          reset;
  logic          i_wren;
  logic          i_rden;
  logic [DW-1:0] i_wrdata;
  logic          o_full;
  logic          o_empty;
  logic          o_alm_full;
  logic          o_alm_empty;
  logic [DW-1:0] o_rddata;

  int tests;
  int failed;

  logic [DW-1:0] q[$];
  logic [DW-1:0] exp_rd;

  fifo_modport #(
    .DATA_W(DW), .DEPTH(DEPTH), .ALM_FULL_TH(AFTH), .ALM_EMPTY_TH(AETH)
  ) dut (
    .clk(clk),
    .reset(reset),
    .i_wren(i_wren),
    .i_rden(i_rden),
    .i_wrdata(i_wrdata),
    .o_full(o_full),
    .o_empty(o_empty),
    .o_alm_full(o_alm_full),
    .o_alm_empty(o_alm_empty),
    .o_rddata(o_rddata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          wr;
    logic          rd;
    logic [DW-1:0] d;
    logic          e_empty;
    logic          e_alm_e;
    logic          e_full;
    logic          e_alm_f;
    logic [DW-1:0] e_rd;
  } vec_t;

  vec_t vecs[20];

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Compare every output against the scoreboard view.
  task automatic chk_model(input string tag);
    int n;
    n = q.size();
    chk({tag, " empty"},   DW'(o_empty),     DW'(n == 0));
    chk({tag, " full"},    DW'(o_full),      DW'(n == DEPTH));
    chk({tag, " alm_e"},   DW'(o_alm_empty), DW'(n <= AETH));
    chk({tag, " alm_f"},   DW'(o_alm_full),  DW'(n >= AFTH));
    chk({tag, " rddata"},  o_rddata,         exp_rd);
  endtask

  // One clock of stimulus. Inputs change 1 time unit after the rising edge,
  // and outputs are sampled 1 time unit after the next rising edge.
  task automatic cyc(input logic wr, input logic rd, input logic [DW-1:0] d, input string tag);
    logic wr_ok;
    logic rd_ok;
    i_wren   = wr;
    i_rden   = rd;
    i_wrdata = d;
    @(posedge clk);
    #1;
    wr_ok = wr && (q.size() < DEPTH);
    rd_ok = rd && (q.size() > 0);
    if (rd_ok) exp_rd = q.pop_front();
    if (wr_ok) q.push_back(d);
    chk_model(tag);
  endtask

  function automatic vec_t mk(input logic wr, input logic rd, input logic [DW-1:0] d,
                              input logic ee, input logic ae, input logic [DW-1:0] er);
    vec_t v;
    v.wr = wr; v.rd = rd; v.d = d;
    v.e_empty = ee; v.e_alm_e = ae; v.e_full = 1'b0; v.e_alm_f = 1'b0;
    v.e_rd = er;
    return v;
  endfunction

  // Watchdog: the run must end by itself even if the DUT misbehaves.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, tests %0d", tests);
    $fatal(1, "timeout");
  end

  initial begin
    int cycles;
    int wrote;
    tests  = 0;
    failed = 0;
    exp_rd = '0;

    // Expected outputs after each vector. All values are hand-computed.
    vecs[0]  = mk(1, 0, 128'h1,  0, 1, 128'h0);
    vecs[1]  = mk(1, 0, 128'h2,  0, 1, 128'h0);
    vecs[2]  = mk(1, 0, 128'h3,  0, 1, 128'h0);
    vecs[3]  = mk(0, 1, 128'h0,  0, 1, 128'h1);
    vecs[4]  = mk(0, 1, 128'h0,  0, 1, 128'h2);
    vecs[5]  = mk(0, 1, 128'h0,  1, 1, 128'h3);
    vecs[6]  = mk(0, 1, 128'h0,  1, 1, 128'h3);   // underflow
    vecs[7]  = mk(1, 1, 128'h77, 0, 1, 128'h3);   // both on empty
    vecs[8]  = mk(1, 0, 128'hA1, 0, 1, 128'h3);
    vecs[9]  = mk(1, 0, 128'hA2, 0, 1, 128'h3);
    vecs[10] = mk(1, 0, 128'hA3, 0, 1, 128'h3);   // count 4
    vecs[11] = mk(1, 0, 128'hA4, 0, 0, 128'h3);   // count 5
    vecs[12] = mk(0, 1, 128'h0,  0, 1, 128'h77);  // count 4
    vecs[13] = mk(1, 1, 128'hA5, 0, 1, 128'hA1);  // count 4
    vecs[14] = mk(1, 0, 128'hA6, 0, 0, 128'hA1);  // count 5
    vecs[15] = mk(0, 1, 128'h0,  0, 1, 128'hA2);
    vecs[16] = mk(0, 1, 128'h0,  0, 1, 128'hA3);
    vecs[17] = mk(0, 1, 128'h0,  0, 1, 128'hA4);
    vecs[18] = mk(0, 1, 128'h0,  0, 1, 128'hA5);
    vecs[19] = mk(0, 1, 128'h0,  1, 1, 128'hA6);

    // Reset held low for 3 cycles while the inputs are random.
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      i_wren   = 1'($urandom);
      i_rden   = 1'($urandom);
      i_wrdata = {$urandom, $urandom, $urandom, $urandom};
      @(posedge clk);
      #1;
    end
    chk("reset empty",  DW'(o_empty),     DW'(1));
    chk("reset alm_e",  DW'(o_alm_empty), DW'(1));
    chk("reset full",   DW'(o_full),      DW'(0));
    chk("reset alm_f",  DW'(o_alm_full),  DW'(0));
    chk("reset rddata", o_rddata,         '0);
    $display("[TB] reset checked");
    i_wren = 1'b0; i_rden = 1'b0; i_wrdata = '0;
    reset = 1'b1;

    // Table-driven vectors.
    for (int i = 0; i < 20; i++) begin
      i_wren   = vecs[i].wr;
      i_rden   = vecs[i].rd;
      i_wrdata = vecs[i].d;
      @(posedge clk);
      #1;
      $display("[TB] vec %0d wr=%0b rd=%0b d=%h -> rddata=%h empty=%0b alm_e=%0b",
               i, vecs[i].wr, vecs[i].rd, vecs[i].d, o_rddata, o_empty, o_alm_empty);
      chk($sformatf("vec%0d empty", i),  DW'(o_empty),     DW'(vecs[i].e_empty));
      chk($sformatf("vec%0d alm_e", i),  DW'(o_alm_empty), DW'(vecs[i].e_alm_e));
      chk($sformatf("vec%0d full", i),   DW'(o_full),      DW'(vecs[i].e_full));
      chk($sformatf("vec%0d alm_f", i),  DW'(o_alm_full),  DW'(vecs[i].e_alm_f));
      chk($sformatf("vec%0d rddata", i), o_rddata,         vecs[i].e_rd);
    end
    exp_rd = vecs[19].e_rd;

    // Fill to almost-full, then to full, then attempt an overflow write.
    for (int i = 0; i < AFTH; i++) cyc(1, 0, DW'(32'h1000 + i), "fill");
    chk("fill1020 alm_f", DW'(o_alm_full), DW'(1));
    chk("fill1020 full",  DW'(o_full),     DW'(0));
    for (int i = AFTH; i < DEPTH; i++) cyc(1, 0, DW'(32'h1000 + i), "fill");
    chk("fill1024 full", DW'(o_full), DW'(1));
    cyc(1, 0, 128'hDEAD, "overflow");
    $display("[TB] fill done, overflow write attempted");

    // Drain. The scoreboard never holds 0xDEAD, so an accepted overflow
    // write shows up as a data error.
    for (int i = 0; i < DEPTH; i++) begin
      cyc(0, 1, '0, "drain");
      if (q.size() == AETH) chk("drain alm_e at 4", DW'(o_alm_empty), DW'(1));
      if (q.size() == AETH + 1) chk("drain alm_e at 5", DW'(o_alm_empty), DW'(0));
      chk("drain not DEAD", DW'(o_rddata == 128'hDEAD), DW'(0));
    end
    chk("drain empty", DW'(o_empty), DW'(1));
    cyc(0, 1, '0, "extra read");
    chk("extra read rddata", o_rddata, DW'(32'h1000 + DEPTH - 1));
    $display("[TB] drain done");

    // Simultaneous read+write with 10 entries in the FIFO.
    for (int i = 0; i < 10; i++) cyc(1, 0, DW'(32'h2000 + i), "sim pre");
    for (int i = 0; i < 50; i++) cyc(1, 1, DW'(32'h3000 + i), "sim both");
    for (int i = 0; i < 9; i++) cyc(0, 1, '0, "sim drain");
    chk("sim 1 left not empty", DW'(o_empty), DW'(0));
    cyc(0, 1, '0, "sim drain");
    chk("sim 10 drained empty", DW'(o_empty), DW'(1));
    chk("sim last word", o_rddata, DW'(32'h3000 + 49));
    $display("[TB] simultaneous done");

    // Wrap-around stream of 3000 words with random gaps on both sides.
    wrote  = 0;
    cycles = 0;
    while ((wrote < 3000 || q.size() > 0) && cycles < 20000) begin
      logic w;
      logic r;
      logic [DW-1:0] d;
      w = (wrote < 3000) && ($urandom_range(0, 2) != 0);
      r = ($urandom_range(0, 2) != 0);
      d = {$urandom, $urandom, $urandom, $urandom};
      if (w && q.size() < DEPTH) wrote++;
      cyc(w, r, d, "stream");
      cycles++;
    end
    chk("stream completed", DW'(wrote == 3000 && q.size() == 0), DW'(1));
    $display("[TB] stream done: %0d words in %0d cycles", wrote, cycles);

    // Asynchronous reset pulse between clock edges, in the middle of a stream.
    for (int i = 0; i < 6; i++) cyc(1, 0, DW'(32'h4000 + i), "pre-rst");
    cyc(0, 1, '0, "pre-rst");
    cyc(0, 1, '0, "pre-rst");
    #2;
    reset = 1'b0;
    #1;
    chk("async rst empty",  DW'(o_empty),     DW'(1));
    chk("async rst alm_e",  DW'(o_alm_empty), DW'(1));
    chk("async rst full",   DW'(o_full),      DW'(0));
    chk("async rst alm_f",  DW'(o_alm_full),  DW'(0));
    chk("async rst rddata", o_rddata,         '0);
    #1;
    reset = 1'b1;
    q.delete();
    exp_rd = '0;
    $display("[TB] async reset pulse checked");
    cyc(1, 0, 128'h5555, "post-rst");
    cyc(0, 1, '0, "post-rst");
    cyc(0, 1, '0, "post-rst underflow");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
